// File: rtl/goose_sprite_if.sv
// Beam-in / LUT / RGB-out bundle for goose_sprite_renderer.
//   master : beam source, LUT model and colour sink (drives hpos/vpos/display_on/vsync/anim_en/lut_pixel)
//   slave  : the renderer (drives lut_x/lut_y/lut_frame/rgb/rgb_valid)
// The mirror signal exists only when GOOSE_SPRITE_MIRROR_EN is defined.
interface goose_sprite_if;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       vsync;
  logic       anim_en;
`ifdef GOOSE_SPRITE_MIRROR_EN
  logic       mirror;
`endif
  logic [4:0] lut_x;
  logic [4:0] lut_y;
  logic [2:0] lut_frame;
  logic [2:0] lut_pixel;
  logic [5:0] rgb;
  logic       rgb_valid;

  modport master (
`ifdef GOOSE_SPRITE_MIRROR_EN
    output mirror,
`endif
    output hpos, vpos, display_on, vsync, anim_en, lut_pixel,
    input  lut_x, lut_y, lut_frame, rgb, rgb_valid
  );

  modport slave (
`ifdef GOOSE_SPRITE_MIRROR_EN
    input  mirror,
`endif
    input  hpos, vpos, display_on, vsync, anim_en, lut_pixel,
    output lut_x, lut_y, lut_frame, rgb, rgb_valid
  );
endinterface

// File: rtl/goose_sprite_renderer.sv
// Sprite renderer: maps the VGA beam position onto a 32x32 bitmap drawn at an
// integer scale, addresses the frame LUTs and converts the returned palette
// index to RGB222 through a 2-stage pipeline. Also owns the animation frame
// counter, which advances on vsync rising edges.
// Ports:
//   clk, rst_n : pixel clock, asynchronous active-low reset
//   bus        : goose_sprite_if.slave
//                in : hpos, vpos, display_on, vsync, anim_en, lut_pixel (, mirror)
//                out: lut_x, lut_y, lut_frame, rgb, rgb_valid (all registered)
// Optional feature macro: GOOSE_SPRITE_MIRROR_EN (adds bus.mirror horizontal flip).
module goose_sprite_renderer #(
  parameter int unsigned SCALE_LOG2  = 2,
  parameter int unsigned SPR_X0      = 256,
  parameter int unsigned SPR_Y0      = 176,
  parameter int unsigned NUM_FRAMES  = 8,
  parameter int unsigned FRAME_TICKS = 6,
  parameter logic [5:0]  BG_RGB      = 6'b000001
) (
  input  logic           clk,
  input  logic           rst_n,
  goose_sprite_if.slave  bus
);

  localparam int unsigned CW   = 11;
  localparam int unsigned BOX  = 32 << SCALE_LOG2;
  localparam int unsigned TW   = 6;
  localparam int unsigned FW   = 3;

  // Palette for indices 1..7; index 0 is transparent and never looked up here.
  function automatic logic [5:0] palette(input logic [2:0] idx);
    logic [5:0] c;
    c = 6'b000000;
    case (idx)
      3'd1:    c = 6'b111111;
      3'd2:    c = 6'b101010;
      3'd3:    c = 6'b010101;
      3'd4:    c = 6'b000000;
      3'd5:    c = 6'b111100;
      3'd6:    c = 6'b110000;
      3'd7:    c = 6'b001100;
      default: c = 6'b000000;
    endcase
    return c;
  endfunction

  logic [CW-1:0] dx_c, dy_c;
  logic          in_box_c;
  logic [4:0]    col_c, row_c, lut_x_c;
  logic          in_box, disp_d;
  logic          vsync_q, rise_c;
  logic [TW-1:0] tick;

  // Sprite-relative offsets; bit CW-1 is the sign, so positions left of or
  // above the sprite are rejected instead of wrapping into the box.
  assign dx_c = {1'b0, bus.hpos} - CW'(SPR_X0);
  assign dy_c = {1'b0, bus.vpos} - CW'(SPR_Y0);

  assign in_box_c = bus.display_on
                  && !dx_c[CW-1] && (dx_c < CW'(BOX))
                  && !dy_c[CW-1] && (dy_c < CW'(BOX));

  assign col_c = dx_c[SCALE_LOG2+4:SCALE_LOG2];
  assign row_c = dy_c[SCALE_LOG2+4:SCALE_LOG2];

  // 31 - col equals the bitwise complement for a 5-bit column.
`ifdef GOOSE_SPRITE_MIRROR_EN
  assign lut_x_c = bus.mirror ? ~col_c : col_c;
`else
  assign lut_x_c = col_c;
`endif

  // Stage 1: LUT address plus in_box/display_on delay; address holds outside the box.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.lut_x <= 5'd0;
      bus.lut_y <= 5'd0;
      in_box    <= 1'b0;
      disp_d    <= 1'b0;
    end else begin
      in_box <= in_box_c;
      disp_d <= bus.display_on;
      if (in_box_c) begin
        bus.lut_x <= lut_x_c;
        bus.lut_y <= row_c;
      end
    end
  end

  // Stage 2: colour from the LUT's combinational palette index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rgb       <= 6'd0;
      bus.rgb_valid <= 1'b0;
    end else begin
      bus.rgb_valid <= disp_d;
      if (!disp_d)
        bus.rgb <= 6'd0;
      else if (!in_box || bus.lut_pixel == 3'd0)
        bus.rgb <= BG_RGB;
      else
        bus.rgb <= palette(bus.lut_pixel);
    end
  end

  assign rise_c = bus.vsync & ~vsync_q;

  // Animation: frame advances every FRAME_TICKS vsync rising edges, only when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q       <= 1'b0;
      tick          <= TW'(0);
      bus.lut_frame <= FW'(0);
    end else begin
      vsync_q <= bus.vsync;
      if (rise_c && bus.anim_en) begin
        if (tick == TW'(FRAME_TICKS - 1)) begin
          tick          <= TW'(0);
          bus.lut_frame <= (bus.lut_frame == FW'(NUM_FRAMES - 1)) ? FW'(0)
                                                                  : bus.lut_frame + FW'(1);
        end else begin
          tick <= tick + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_goose_sprite_renderer.sv
// Scoreboard bench for goose_sprite_renderer: a LUT model answers lut_pixel,
// expected LUT addresses and colours are queued per driven pixel and compared
// when they come due. Also exercises the animation counter and async reset.
module tb_goose_sprite_renderer;

  localparam int SCALE_LOG2  = 2;
  localparam int SPR_X0      = 256;
  localparam int SPR_Y0      = 176;
  localparam int NUM_FRAMES  = 8;
  localparam int FRAME_TICKS = 6;
  localparam int BOX         = 32 << SCALE_LOG2;
  localparam logic [5:0] BG  = 6'b000001;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  goose_sprite_if bus();

  goose_sprite_renderer #(
    .SCALE_LOG2 (SCALE_LOG2),
    .SPR_X0     (SPR_X0),
    .SPR_Y0     (SPR_Y0),
    .NUM_FRAMES (NUM_FRAMES),
    .FRAME_TICKS(FRAME_TICKS),
    .BG_RGB     (BG)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct { int due; logic [4:0] x; logic [4:0] y; } lut_exp_t;
  typedef struct { int due; logic [5:0] rgb; logic valid; } rgb_exp_t;

  lut_exp_t lq[$];
  rgb_exp_t rq[$];

  int         cyc;
  int         n_vec;
  int         n_err;
  logic [4:0] mx, my;
  logic [2:0] m_frame;
  int         m_tick;
  logic       m_mir;

  function automatic logic [2:0] lut_model(input logic [4:0] x, input logic [4:0] y,
                                           input logic [2:0] f);
    return 3'(x) + 3'(y) * 3'd3 + f;
  endfunction

  function automatic logic [5:0] pal(input logic [2:0] i);
    logic [5:0] c;
    case (i)
      3'd1:    c = 6'b111111;
      3'd2:    c = 6'b101010;
      3'd3:    c = 6'b010101;
      3'd4:    c = 6'b000000;
      3'd5:    c = 6'b111100;
      3'd6:    c = 6'b110000;
      3'd7:    c = 6'b001100;
      default: c = 6'b000000;
    endcase
    return c;
  endfunction

  // Frame LUT stand-in: combinational palette index from the DUT's address.
  always_comb bus.lut_pixel = lut_model(bus.lut_x, bus.lut_y, bus.lut_frame);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock; then retire every scoreboard entry that has come due.
  task automatic step();
    lut_exp_t le;
    rgb_exp_t re;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    while (lq.size() > 0 && lq[0].due <= cyc) begin
      le = lq.pop_front();
      check_val("lut_x", 32'(bus.lut_x), 32'(le.x));
      check_val("lut_y", 32'(bus.lut_y), 32'(le.y));
    end
    while (rq.size() > 0 && rq[0].due <= cyc) begin
      re = rq.pop_front();
      check_val("rgb", 32'(bus.rgb), 32'(re.rgb));
      check_val("rgb_valid", 32'(bus.rgb_valid), 32'(re.valid));
    end
  endtask

  task automatic drive_pix(input logic [9:0] h, input logic [9:0] v, input logic disp);
    int         dx, dy;
    logic       inb;
    logic [2:0] p;
    logic [5:0] e;
    bus.hpos       = h;
    bus.vpos       = v;
    bus.display_on = disp;
`ifdef GOOSE_SPRITE_MIRROR_EN
    bus.mirror     = m_mir;
`endif
    dx  = int'(h) - SPR_X0;
    dy  = int'(v) - SPR_Y0;
    inb = disp && dx >= 0 && dx < BOX && dy >= 0 && dy < BOX;
    if (inb) begin
      mx = 5'(dx >> SCALE_LOG2);
      if (m_mir) mx = 5'd31 - mx;
      my = 5'(dy >> SCALE_LOG2);
    end
    lq.push_back('{cyc + 1, mx, my});
    if (!disp) e = 6'd0;
    else if (!inb) e = BG;
    else begin
      p = lut_model(mx, my, m_frame);
      e = (p == 3'd0) ? BG : pal(p);
    end
    rq.push_back('{cyc + 2, e, disp});
    step();
  endtask

  task automatic vsync_pulse(input int len);
    bus.vsync = 1'b1;
    if (bus.anim_en) begin
      if (m_tick == FRAME_TICKS - 1) begin
        m_tick  = 0;
        m_frame = (int'(m_frame) == NUM_FRAMES - 1) ? 3'd0 : m_frame + 3'd1;
      end else begin
        m_tick++;
      end
    end
    repeat (len) step();
    bus.vsync = 1'b0;
    repeat (2) step();
    check_val("lut_frame", 32'(bus.lut_frame), 32'(m_frame));
  endtask

  task automatic drain();
    repeat (3) step();
  endtask

  initial begin
    cyc = 0; n_vec = 0; n_err = 0;
    mx = 5'd0; my = 5'd0; m_frame = 3'd0; m_tick = 0; m_mir = 1'b0;
    rst_n = 1'b0;
    bus.hpos = 10'd0; bus.vpos = 10'd0; bus.display_on = 1'b0;
    bus.vsync = 1'b0; bus.anim_en = 1'b0;
`ifdef GOOSE_SPRITE_MIRROR_EN
    bus.mirror = 1'b0;
`endif
    step(); step();
    check_val("rst lut_x", 32'(bus.lut_x), 32'd0);
    check_val("rst lut_y", 32'(bus.lut_y), 32'd0);
    check_val("rst lut_frame", 32'(bus.lut_frame), 32'd0);
    check_val("rst rgb", 32'(bus.rgb), 32'd0);
    check_val("rst rgb_valid", 32'(bus.rgb_valid), 32'd0);
    rst_n = 1'b1;

    // Directed corners: origin, far corner, one past, display off, negative offsets.
    drive_pix(10'd256, 10'd176, 1'b1);
    drive_pix(10'd383, 10'd303, 1'b1);
    drive_pix(10'd384, 10'd303, 1'b1);
    drive_pix(10'd383, 10'd304, 1'b1);
    drive_pix(10'd300, 10'd200, 1'b0);
    drive_pix(10'd10,  10'd10,  1'b1);
    drive_pix(10'd255, 10'd200, 1'b1);
    drive_pix(10'd300, 10'd175, 1'b1);
    for (int h = 250; h <= 260; h++) drive_pix(10'(h), 10'd180, 1'b1);
    for (int i = 0; i < 40; i++)
      drive_pix(10'($urandom_range(240, 400)), 10'($urandom_range(160, 320)),
                $urandom_range(0, 7) != 0);
    drain();

    // Animation: 6 pulses -> frame 1, a 100-clock vsync counts once, wrap after 48.
    bus.display_on = 1'b0;
    bus.anim_en    = 1'b1;
    for (int i = 0; i < 6; i++) vsync_pulse(1);
    vsync_pulse(100);
    for (int i = 0; i < 41; i++) vsync_pulse(1);
    check_val("frame wrap", 32'(bus.lut_frame), 32'd0);
    bus.anim_en = 1'b0;
    for (int i = 0; i < 20; i++) vsync_pulse(1);
    bus.anim_en = 1'b1;
    for (int i = 0; i < 10; i++) vsync_pulse(1);

    // Pixels again with a non-zero frame feeding the LUT.
    for (int i = 0; i < 30; i++)
      drive_pix(10'($urandom_range(250, 390)), 10'($urandom_range(170, 310)), 1'b1);
    drain();

    // Asynchronous reset mid-line.
    drive_pix(10'd300, 10'd220, 1'b1);
    drive_pix(10'd304, 10'd220, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_val("async rst lut_x", 32'(bus.lut_x), 32'd0);
    check_val("async rst lut_y", 32'(bus.lut_y), 32'd0);
    check_val("async rst lut_frame", 32'(bus.lut_frame), 32'd0);
    check_val("async rst rgb", 32'(bus.rgb), 32'd0);
    check_val("async rst rgb_valid", 32'(bus.rgb_valid), 32'd0);
    lq.delete(); rq.delete();
    mx = 5'd0; my = 5'd0; m_frame = 3'd0; m_tick = 0;
    step();
    rst_n = 1'b1;
    drive_pix(10'd260, 10'd180, 1'b1);
    check_val("post-rst rgb_valid", 32'(bus.rgb_valid), 32'd0);
    drive_pix(10'd264, 10'd184, 1'b1);
    drain();

`ifdef GOOSE_SPRITE_MIRROR_EN
    m_mir = 1'b1;
    drive_pix(10'd256, 10'd176, 1'b1);
    drive_pix(10'd260, 10'd176, 1'b1);
    drive_pix(10'd383, 10'd200, 1'b1);
    drain();
    m_mir = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/goose_sprite_renderer.md
Name: goose_sprite_renderer

Overview:
- Consumer side of the 32×32 frame bitmaps.
- Takes the VGA beam position and computes sprite-relative coordinates at an integer scale.
- Drives the x/y/frame address to the frame LUTs and maps the returned 3-bit palette index to RGB222 through a 2-stage pipeline.
- Owns the animation frame counter, which advances on vsync.

Parameters:
- SCALE_LOG2, 2, sprite magnification; each bitmap texel covers 2^SCALE_LOG2 × 2^SCALE_LOG2 screen pixels.
- SPR_X0, 256, screen column of the sprite's left edge.
- SPR_Y0, 176, screen row of the sprite's top edge.
- NUM_FRAMES, 8, number of animation frames; legal range 1–8.
- FRAME_TICKS, 6, vsync rising edges per animation frame; legal range 1–63.
- BG_RGB, 6'b000001, RGB222 background colour.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- hpos  in  10  beam column
- vpos  in  10  beam row
- display_on  in  1  visible-area flag
- vsync  in  1  vertical sync level (active-high)
- anim_en  in  1  1 = animation advances
- lut_x  out  5  bitmap column to the frame LUTs
- lut_y  out  5  bitmap row to the frame LUTs
- lut_frame  out  3  selected animation frame
- lut_pixel  in  3  palette index returned combinationally by the LUTs
- rgb  out  6  RGB222 {R[1:0],G[1:0],B[1:0]}
- rgb_valid  out  1  rgb corresponds to a visible pixel

Behaviour:
- Reset values: lut_x=0, lut_y=0, lut_frame=0, rgb=0, rgb_valid=0. Internal in_box=0, vsync_q=0, tick counter=0.
- Stage 1 (registered at edge N+1 from inputs sampled at edge N):
  - dx = hpos−SPR_X0, dy = vpos−SPR_Y0, computed 11-bit signed.
  - in_box = display_on & 0 ≤ dx < 32<<SCALE_LOG2 & 0 ≤ dy < 32<<SCALE_LOG2.
  - lut_x = dx[SCALE_LOG2+4:SCALE_LOG2], lut_y = dy[SCALE_LOG2+4:SCALE_LOG2].
  - Outside the box, lut_x and lut_y hold their previous values.
  - The display_on delay is registered alongside.
- Stage 2 (edge N+2):
  - rgb_valid = delayed display_on.
  - If !display_on_d: rgb=0.
  - Else if !in_box or lut_pixel==0 (transparent): rgb=BG_RGB.
  - Else rgb = PALETTE[lut_pixel].
  - PALETTE 1..7 = 6'b111111, 6'b101010, 6'b010101, 6'b000000, 6'b111100, 6'b110000, 6'b001100.
- Latency from hpos/vpos to rgb is exactly 2 clocks. There is no stall and no back-pressure; a new pixel is accepted every clock.
- Animation:
  - vsync_q registers vsync. A rising edge is vsync & !vsync_q.
  - On a rising edge with anim_en=1: if tick==FRAME_TICKS−1, then tick←0 and lut_frame←(lut_frame==NUM_FRAMES−1)?0:lut_frame+1; otherwise tick←tick+1.
  - anim_en=0 freezes both tick and lut_frame; neither resets.
  - lut_frame changes only in the cycle after a vsync rising edge, so there is no mid-frame tearing.
- Boundaries:
  - NUM_FRAMES=1 keeps lut_frame at 0.
  - hpos/vpos below SPR_X0/SPR_Y0 give negative dx/dy, so in_box=0; no unsigned wrap artefacts are permitted.
  - A vsync held high for multiple cycles counts once.
  - Reset asserted mid-line clears the pipeline immediately (asynchronous). The first valid rgb is 2 clocks after release.

Optional Feature:
- Macro GOOSE_SPRITE_MIRROR_EN.
- Defined: adds input port mirror (1 bit), sampled in stage 1. When mirror=1, lut_x = 31 − dx[SCALE_LOG2+4:SCALE_LOG2] (horizontal flip). lut_y is unaffected. Latency is unchanged.
- Undefined: the port is absent and lut_x is never flipped.

Test Plan:
- Reset release, then display_on=1, hpos=256, vpos=176 → after 2 clocks lut_x=0, lut_y=0, rgb=PALETTE[lut_pixel]; with lut_pixel=0, rgb=6'b000001.
- hpos=383, vpos=303 (SCALE_LOG2=2) → lut_x=31, lut_y=31, in_box=1; hpos=384 → rgb=BG_RGB regardless of lut_pixel.
- display_on=0, any position → rgb=0 and rgb_valid=0 two clocks later. Pixel stream hpos 250..260 → rgb sequence is the input sequence delayed by exactly 2 clocks.
- anim_en=1, 6 vsync pulses → lut_frame 0→1. After 48 pulses lut_frame wraps 7→0. A vsync held high for 100 clocks gives one tick.
- anim_en=0 over 20 vsync pulses → lut_frame and tick unchanged. rst_n pulsed low mid-frame → all outputs 0 asynchronously.
- GOOSE_SPRITE_MIRROR_EN defined, mirror=1, hpos=256 → lut_x=31; hpos=260 → lut_x=30.
